pipe_stage_reg: RTL and testbench

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

---
 rtl/pipe_pkg.sv | 14 +
 rtl/pipe_slot.sv | 37 +++
 rtl/pipe_stage_reg.sv | 123 ++++++++++++
 tb/tb_pipe_stage_reg.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared widths and helpers for the pipeline stage register
package pipe_pkg;

    localparam int PIPE_DEFAULT_WIDTH = 64;
    localparam int PIPE_OCC_W         = 2;

    typedef logic [PIPE_OCC_W-1:0] occ_t;

    // Number of occupied slots given the two valid bits.
    function automatic occ_t occ_count(input logic main_valid, input logic skid_valid);
        return occ_t'(main_valid) + occ_t'(skid_valid);
    endfunction

endpackage

// File: rtl/pipe_slot.sv
// rtl/pipe_slot.sv - one pipeline slot: valid bit plus data register with load, clear and hold
module pipe_slot
    import pipe_pkg::*;
#(
    parameter int               WIDTH      = PIPE_DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] RESET_DATA = '0
) (
    input  logic             clk,
    input  logic             Reset,
    input  logic             i_flush,
    input  logic             i_load,
    input  logic             i_unload,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data
);

    logic             r_valid;
    logic [WIDTH-1:0] r_data;

    // Clear beats load beats unload; data only changes on clear or load.
    always_ff @(posedge clk) begin
        if (Reset || i_flush) begin
            r_valid <= 1'b0;
            r_data  <= RESET_DATA;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
        end else if (i_unload) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - pipeline stage register; PIPE_STAGE_SKID_EN adds a skid slot with registered in_ready
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int               WIDTH      = PIPE_DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] RESET_DATA = '0
) (
    input  logic                  clk,
    input  logic                  Reset,
    input  logic                  Flush,
    input  logic                  Stall,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH-1:0]      out_data,
    output logic [PIPE_OCC_W-1:0] occupancy
);

    logic             w_main_valid;
    logic [WIDTH-1:0] w_main_data;
    logic             w_main_load;
    logic             w_main_unload;
    logic [WIDTH-1:0] w_main_din;
    logic             w_main_valid_nxt;
    logic             w_skid_valid_nxt;
    logic             w_out_xfer;
    logic             w_in_xfer;
    occ_t             r_occupancy;

    // Stall gates the output side only; the input side may still fill the skid slot.
    assign w_out_xfer = w_main_valid && out_ready && !Stall;
    assign w_in_xfer  = in_valid && in_ready;

`ifdef PIPE_STAGE_SKID_EN
    logic             w_skid_valid;
    logic [WIDTH-1:0] w_skid_data;
    logic             w_skid_load;
    logic             w_skid_unload;

    // Skid valid is a register, so in_ready has no path from out_ready or Stall.
    assign in_ready = !w_skid_valid;

    // Refill main from skid first; otherwise main takes input when empty or draining.
    always_comb begin
        w_main_load   = 1'b0;
        w_main_unload = 1'b0;
        w_main_din    = in_data;
        w_skid_load   = 1'b0;
        w_skid_unload = 1'b0;
        if (w_skid_valid) begin
            if (w_out_xfer) begin
                w_main_load   = 1'b1;
                w_main_din    = w_skid_data;
                w_skid_unload = 1'b1;
            end
        end else begin
            if (w_in_xfer && (!w_main_valid || w_out_xfer)) begin
                w_main_load = 1'b1;
            end else if (w_out_xfer) begin
                w_main_unload = 1'b1;
            end
            if (w_in_xfer && w_main_valid && !w_out_xfer) begin
                w_skid_load = 1'b1;
            end
        end
    end

    assign w_skid_valid_nxt = w_skid_load || (w_skid_valid && !w_skid_unload);

    pipe_slot #(
        .WIDTH      (WIDTH),
        .RESET_DATA (RESET_DATA)
    ) u_skid (
        .clk      (clk),
        .Reset    (Reset),
        .i_flush  (Flush),
        .i_load   (w_skid_load),
        .i_unload (w_skid_unload),
        .i_data   (in_data),
        .o_valid  (w_skid_valid),
        .o_data   (w_skid_data)
    );
`else
    // Single slot: accept when empty or when the head leaves this cycle.
    assign in_ready         = !w_main_valid || w_out_xfer;
    assign w_main_load      = w_in_xfer;
    assign w_main_unload    = w_out_xfer && !w_in_xfer;
    assign w_main_din       = in_data;
    assign w_skid_valid_nxt = 1'b0;
`endif

    assign w_main_valid_nxt = w_main_load || (w_main_valid && !w_main_unload);

    pipe_slot #(
        .WIDTH      (WIDTH),
        .RESET_DATA (RESET_DATA)
    ) u_main (
        .clk      (clk),
        .Reset    (Reset),
        .i_flush  (Flush),
        .i_load   (w_main_load),
        .i_unload (w_main_unload),
        .i_data   (w_main_din),
        .o_valid  (w_main_valid),
        .o_data   (w_main_data)
    );

    // Occupancy tracks the next-state valid bits so it lines up with the slots.
    always_ff @(posedge clk) begin
        if (Reset || Flush) begin
            r_occupancy <= '0;
        end else begin
            r_occupancy <= occ_count(w_main_valid_nxt, w_skid_valid_nxt);
        end
    end

    assign out_valid = w_main_valid;
    assign out_data  = w_main_data;
    assign occupancy = r_occupancy;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - self-checking bench for pipe_stage_reg in either PIPE_STAGE_SKID_EN build
module tb_pipe_stage_reg;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         Reset, Flush, Stall;
    logic         in_valid, in_ready, out_valid, out_ready;
    logic [W-1:0] in_data, out_data;
    logic [1:0]   occupancy;

    int checks   = 0;
    int failures = 0;
    int n_out    = 0;
    int n0;

    logic [W-1:0] sb[$];

    typedef struct {
        logic         iv;
        logic [W-1:0] id;
        logic         ordy;
        logic         e_ov;
        logic [W-1:0] e_od;
        logic [1:0]   e_occ;
        logic         e_rdy;
    } vec_t;

    vec_t vecs[9];

    always #5 clk = ~clk;

    pipe_stage_reg #(.WIDTH(W)) dut (
        .clk       (clk),
        .Reset     (Reset),
        .Flush     (Flush),
        .Stall     (Stall),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .occupancy (occupancy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Evaluate handshakes at the negedge, then advance one rising edge and settle.
    task automatic tick();
        logic [W-1:0] exp_d;
        @(negedge clk);
`ifndef PIPE_STAGE_SKID_EN
        chk("occ_max1", {31'd0, occupancy <= 2'd1}, 32'd1);
`endif
        if (Reset || Flush) begin
            sb.delete();
        end else begin
            if (out_valid && out_ready && !Stall) begin
                n_out++;
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL sb_underflow actual=%0h required=none", out_data);
                end else begin
                    exp_d = sb.pop_front();
                    if (out_data !== exp_d) begin
                        failures++;
                        $display("FAIL sb_data actual=%0h required=%0h", out_data, exp_d);
                    end
                end
            end
            if (in_valid && in_ready) sb.push_back(in_data);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 8; i++) begin
            vecs[i] = '{1'b1, W'(i + 1), 1'b1, 1'b1, W'(i + 1), 2'd1, 1'b1};
        end
        vecs[8] = '{1'b0, W'(0), 1'b1, 1'b0, W'(8), 2'd0, 1'b1};

        Reset = 1'b1; Flush = 1'b0; Stall = 1'b0;
        in_valid = 1'b1; in_data = 16'h00AA; out_ready = 1'b0;
        tick();
        tick();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_occ", occupancy, 0);
        chk("rst_in_ready", in_ready, 1);
        Reset = 1'b0; in_valid = 1'b0;
        tick();
        chk("rst_idle_valid", out_valid, 0);

        // Streaming 1..8 then drain; data holds after the final unload.
        for (int i = 0; i < 9; i++) begin
            in_valid = vecs[i].iv; in_data = vecs[i].id; out_ready = vecs[i].ordy;
            #1;
            chk("stream_in_ready", in_ready, vecs[i].e_rdy);
            tick();
            chk("stream_out_valid", out_valid, vecs[i].e_ov);
            chk("stream_out_data", out_data, vecs[i].e_od);
            chk("stream_occ", occupancy, vecs[i].e_occ);
        end
        chk("stream_count", n_out, 8);

        // Backpressure with 0x10, 0x11, 0x12.
        out_ready = 1'b0; in_valid = 1'b1; in_data = 16'h0010;
        tick();
        chk("bp_occ_a", occupancy, 1);
        chk("bp_data_a", out_data, 16'h0010);
`ifdef PIPE_STAGE_SKID_EN
        chk("bp_rdy_a", in_ready, 1);
        in_data = 16'h0011;
        tick();
        chk("bp_occ_b", occupancy, 2);
        chk("bp_rdy_b", in_ready, 0);
        chk("bp_data_b", out_data, 16'h0010);
        in_data = 16'h0012;
        tick();
        chk("bp_occ_c", occupancy, 2);
        chk("bp_data_c", out_data, 16'h0010);
        out_ready = 1'b1;
        tick();
        chk("bp_data_d", out_data, 16'h0011);
        chk("bp_occ_d", occupancy, 1);
        chk("bp_rdy_d", in_ready, 1);
        tick();
        chk("bp_data_e", out_data, 16'h0012);
        chk("bp_occ_e", occupancy, 1);
`else
        chk("bp_rdy_a", in_ready, 0);
        in_data = 16'h0011;
        tick();
        chk("bp_data_b", out_data, 16'h0010);
        chk("bp_occ_b", occupancy, 1);
        out_ready = 1'b1;
        #1;
        chk("bp_rdy_comb", in_ready, 1);
        tick();
        chk("bp_data_d", out_data, 16'h0011);
        chk("bp_occ_d", occupancy, 1);
        in_data = 16'h0012;
        tick();
        chk("bp_data_e", out_data, 16'h0012);
`endif
        in_valid = 1'b0;
        tick();
        chk("bp_empty_valid", out_valid, 0);
        chk("bp_empty_occ", occupancy, 0);

        // Stall holds the head 0x55 until released, then it leaves exactly once.
        out_ready = 1'b0; in_valid = 1'b1; in_data = 16'h0055;
        tick();
        in_valid = 1'b0; out_ready = 1'b1; Stall = 1'b1;
        n0 = n_out;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_valid", out_valid, 1);
            chk("stall_data", out_data, 16'h0055);
`ifdef PIPE_STAGE_SKID_EN
            chk("stall_in_ready", in_ready, 1);
`else
            chk("stall_in_ready", in_ready, 0);
`endif
        end
        chk("stall_no_xfer", n_out, n0);
        Stall = 1'b0;
        tick();
        chk("stall_release_cnt", n_out, n0 + 1);
        chk("stall_release_valid", out_valid, 0);
        tick();
        chk("stall_once", n_out, n0 + 1);

        // Flush while full, with 0x77 offered in the Flush cycle.
        out_ready = 1'b0; in_valid = 1'b1; in_data = 16'h00A0;
        tick();
        in_data = 16'h00A1;
        tick();
`ifdef PIPE_STAGE_SKID_EN
        chk("flush_pre_occ", occupancy, 2);
`else
        chk("flush_pre_occ", occupancy, 1);
`endif
        Flush = 1'b1; in_data = 16'h0077;
        tick();
        chk("flush_valid", out_valid, 0);
        chk("flush_occ", occupancy, 0);
        chk("flush_data", out_data, 0);
        chk("flush_in_ready", in_ready, 1);
        Flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        tick();
        tick();
        chk("flush_after_valid", out_valid, 0);

        // Reset mid-transfer drops the held entry and the one offered during Reset.
        out_ready = 1'b0; in_valid = 1'b1; in_data = 16'h0033;
        tick();
        Reset = 1'b1; in_data = 16'h0044;
        tick();
        Reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        tick();
        chk("rst_mid_valid", out_valid, 0);
        chk("rst_mid_occ", occupancy, 0);

        chk("sb_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
